conv_window_buffer: RTL and testbench

- Streaming window generator directly upstream of the convolution ALU.
- Accepts raster-order 12-bit RGB444 pixels one per cycle and buffers WIN-1 previous lines.
- Emits a full WIN x WIN pixel window, packed exactly as the ALU `din` bus expects, with a valid/ready handshake.
- Only fully populated windows are emitted: no border padding, so a frame yields (IMG_W-WIN+1)*(IMG_H-WIN+1) windows.

---
 rtl/conv_window_buffer.sv | 145 ++++++++++++++
 tb/tb_conv_window_buffer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_buffer.sv
//------------------------------------------------------------------------------
// conv_window_buffer : raster pixel stream -> WIN x WIN window stream for the conv ALU
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module conv_window_buffer #(
  parameter int DWIDTH_DAT = 12,
  parameter int WIN        = 3,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DWIDTH_DAT-1:0]          in_pix,
  input  logic                           in_sof,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [WIN*WIN*DWIDTH_DAT-1:0]  out_win,
  output logic [$clog2(IMG_W)-1:0]       out_x,
  output logic [$clog2(IMG_H)-1:0]       out_y,
  output logic                           out_eof,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int WB = WIN*WIN*DWIDTH_DAT;
  localparam logic [XW-1:0] c_X_MAX   = XW'(IMG_W-1);
  localparam logic [YW-1:0] c_Y_MAX   = YW'(IMG_H-1);
  localparam logic [XW-1:0] c_X_FIRST = XW'(WIN-1);
  localparam logic [YW-1:0] c_Y_FIRST = YW'(WIN-1);
  localparam logic [XW-1:0] c_X_HALF  = XW'((WIN-1)/2);
  localparam logic [YW-1:0] c_Y_HALF  = YW'((WIN-1)/2);

  logic [XW-1:0]         r_x, w_px;
  logic [YW-1:0]         r_y, w_py;
  logic                  w_accept, w_load;
  logic [DWIDTH_DAT-1:0] w_lb_out [WIN-1];
  logic [DWIDTH_DAT-1:0] r_win    [WIN][WIN];
  logic [DWIDTH_DAT-1:0] w_nxt    [WIN][WIN];
  logic [WB-1:0]         w_nxt_flat;
  logic                  r_out_valid, r_out_eof;
  logic [WB-1:0]         r_out_win;
  logic [XW-1:0]         r_out_x;
  logic [YW-1:0]         r_out_y;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  // A start-of-frame pixel is always position (0,0), whatever the counters hold.
  assign w_px      = in_sof ? '0 : r_x;
  assign w_py      = in_sof ? '0 : r_y;
  assign w_load    = w_accept && (w_px >= c_X_FIRST) && (w_py >= c_Y_FIRST);

  assign out_valid = r_out_valid;
  assign out_win   = r_out_win;
  assign out_x     = r_out_x;
  assign out_y     = r_out_y;
  assign out_eof   = r_out_eof;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_accept) begin
      if (w_px == c_X_MAX) begin
        r_x <= '0;
        r_y <= (w_py == c_Y_MAX) ? '0 : w_py + 1'b1;
      end else begin
        r_x <= w_px + 1'b1;
        r_y <= w_py;
      end
    end
  end

  // Line k holds the row k+1 above; reads happen before the same-cycle write.
  for (genvar k = 0; k < WIN-1; k++) begin : g_line
    logic [DWIDTH_DAT-1:0] r_mem [IMG_W];
    logic [DWIDTH_DAT-1:0] w_wr;
    if (k == 0) begin : g_head
      assign w_wr = in_pix;
    end else begin : g_tail
      assign w_wr = w_lb_out[k-1];
    end
    assign w_lb_out[k] = r_mem[w_px];
    always_ff @(posedge clk) begin
      if (w_accept) r_mem[w_px] <= w_wr;
    end
  end

  always_comb begin
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN-1; c++) begin
        w_nxt[r][c] = r_win[r][c+1];
      end
    end
    for (int r = 0; r < WIN-1; r++) begin
      w_nxt[r][WIN-1] = w_lb_out[WIN-2-r];
    end
    w_nxt[WIN-1][WIN-1] = in_pix;
  end

  always_comb begin
    w_nxt_flat = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        w_nxt_flat[(r*WIN+c)*DWIDTH_DAT +: DWIDTH_DAT] = w_nxt[r][c];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else if (w_accept) begin
      r_win <= w_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_win   <= '0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_out_eof   <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_win   <= w_nxt_flat;
      r_out_x     <= w_px - c_X_HALF;
      r_out_y     <= w_py - c_Y_HALF;
      r_out_eof   <= (w_px == c_X_MAX) && (w_py == c_Y_MAX);
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv_window_buffer.sv
//------------------------------------------------------------------------------
// tb_conv_window_buffer : self-checking bench for conv_window_buffer (5x4 image, 3x3 window)
//------------------------------------------------------------------------------
`default_nettype none

module tb_conv_window_buffer;

  localparam int DW = 12;
  localparam int WN = 3;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int WB = WN*WN*DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_pix;
  logic          in_sof, in_valid, in_ready;
  logic [WB-1:0] out_win;
  logic [2:0]    out_x;
  logic [1:0]    out_y;
  logic          out_eof, out_valid, out_ready;

  conv_window_buffer #(.DWIDTH_DAT(DW), .WIN(WN), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .in_pix(in_pix), .in_sof(in_sof), .in_valid(in_valid),
    .in_ready(in_ready), .out_win(out_win), .out_x(out_x), .out_y(out_y),
    .out_eof(out_eof), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [WB-1:0] win; int x; int y; bit eof; } win_t;
  typedef struct { int cx; int cy; bit eof; } vec_t;

  win_t exp_q[$];
  win_t got[$];
  vec_t tbl[6];
  int   checks = 0, errors = 0;
  int   mx = 0, my = 0, m_px, m_py;
  int   img[H][W];
  win_t m_e, m_g;

  function automatic logic [WB-1:0] mkwin(input int base, input int cx, input int cy);
    logic [WB-1:0] w = '0;
    for (int r = 0; r < WN; r++)
      for (int c = 0; c < WN; c++)
        w[(r*WN+c)*DW +: DW] = DW'(base + (cy-1+r)*W + (cx-1+c));
    return w;
  endfunction

  task automatic chk(input string nm, input logic [WB-1:0] act, input logic [WB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  // Reference model: image memory indexed by raster position, windows read straight from it.
  always @(negedge clk) begin
    if (rst) begin
      mx = 0; my = 0;
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        if (in_sof) begin m_px = 0; m_py = 0; end
        else begin m_px = mx; m_py = my; end
        img[m_py][m_px] = int'(in_pix);
        if (m_px >= WN-1 && m_py >= WN-1) begin
          m_e.win = '0;
          for (int r = 0; r < WN; r++)
            for (int c = 0; c < WN; c++)
              m_e.win[(r*WN+c)*DW +: DW] = DW'(img[m_py-2+r][m_px-2+c]);
          m_e.x = m_px - 1; m_e.y = m_py - 1; m_e.eof = (m_px == W-1 && m_py == H-1);
          exp_q.push_back(m_e);
        end
        mx = (m_px == W-1) ? 0 : m_px + 1;
        my = (m_px == W-1) ? ((m_py == H-1) ? 0 : m_py + 1) : m_py;
      end
      if (out_valid && out_ready) begin
        m_g.win = out_win; m_g.x = int'(out_x); m_g.y = int'(out_y); m_g.eof = out_eof;
        got.push_back(m_g);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got window x=%0d y=%0d, required none", m_g.x, m_g.y);
        end else begin
          m_e = exp_q.pop_front();
          if (m_g.win !== m_e.win || m_g.x != m_e.x || m_g.y != m_e.y || m_g.eof != m_e.eof) begin
            errors++;
            $display("FAIL sb_window: got x=%0d y=%0d eof=%0d win=%h, required x=%0d y=%0d eof=%0d win=%h",
                     m_g.x, m_g.y, m_g.eof, m_g.win, m_e.x, m_e.y, m_e.eof, m_e.win);
          end
        end
      end
    end
  end

  task automatic drive_pix(input int p, input bit sof, input int pct);
    bit acc = 1'b0;
    int guard = 0;
    in_pix = DW'(p);
    in_sof = sof;
    while (!acc && guard < 200) begin
      in_valid = ($urandom_range(99) < pct);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout: pixel %0d not accepted, required accept within 200 cycles", p);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_table(input string nm, input int base);
    chk1({nm, "_count"}, got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      chk({nm, "_win"}, got[i].win, mkwin(base, tbl[i].cx, tbl[i].cy));
      chk1({nm, "_x"}, got[i].x, tbl[i].cx);
      chk1({nm, "_y"}, got[i].y, tbl[i].cy);
      chk1({nm, "_eof"}, int'(got[i].eof), int'(tbl[i].eof));
    end
  endtask

  initial begin
    int neof;
    tbl[0] = '{1, 1, 1'b0}; tbl[1] = '{2, 1, 1'b0}; tbl[2] = '{3, 1, 1'b0};
    tbl[3] = '{1, 2, 1'b0}; tbl[4] = '{2, 2, 1'b0}; tbl[5] = '{3, 2, 1'b1};
    rst = 1'b1; in_pix = '0; in_sof = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_out_valid", int'(out_valid), 0);
    chk1("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_win", out_win, '0);
    chk1("rst_out_x", int'(out_x), 0);
    chk1("rst_out_y", int'(out_y), 0);
    chk1("rst_out_eof", int'(out_eof), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Free-flowing frame with latency probe
    got.delete();
    for (int i = 0; i < 20; i++) begin
      drive_pix(i, i == 0, 100);
      if (i == 11) chk1("s1_no_early_valid", int'(out_valid), 0);
      if (i == 12) begin
        chk1("s1_latency_valid", int'(out_valid), 1);
        chk("s1_first_win", out_win, mkwin(0, 1, 1));
      end
    end
    idle(5);
    check_table("s1", 0);

    // Backpressure on the first window
    got.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 13; i++) drive_pix(i, i == 0, 100);
    in_pix = DW'(13); in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1("s2_in_ready_low", int'(in_ready), 0);
      chk1("s2_valid_hold", int'(out_valid), 1);
      chk("s2_win_hold", out_win, mkwin(0, 1, 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 13; i < 20; i++) drive_pix(i, 1'b0, 100);
    idle(5);
    check_table("s2", 0);

    // Random input gaps
    got.delete();
    for (int i = 0; i < 20; i++) drive_pix(i, i == 0, 50);
    idle(5);
    check_table("s3", 0);

    // Mid-frame restart
    got.delete();
    for (int i = 0; i < 8; i++) drive_pix(i, i == 0, 100);
    for (int i = 0; i < 20; i++) drive_pix(100 + i, i == 0, 100);
    idle(5);
    check_table("s4", 100);

    // Asynchronous reset with a window pending
    out_ready = 1'b0;
    for (int i = 0; i < 13; i++) drive_pix(i, i == 0, 100);
    chk1("s5_pending_valid", int'(out_valid), 1);
    #1 rst = 1'b1;
    #1;
    chk1("s5_async_valid", int'(out_valid), 0);
    chk1("s5_async_in_ready", int'(in_ready), 1);
    chk("s5_async_win", out_win, '0);
    #4 rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 20; i++) drive_pix(i, i == 0, 100);
    idle(5);
    check_table("s5", 0);

    // Back-to-back frames relying on counter wrap
    got.delete();
    for (int i = 0; i < 40; i++) drive_pix(i % 20, i == 0, 100);
    idle(5);
    chk1("s6_count", got.size(), 12);
    neof = 0;
    foreach (got[i]) neof += int'(got[i].eof);
    chk1("s6_eof_count", neof, 2);
    if (got.size() >= 12) begin
      chk1("s6_eof_6th", int'(got[5].eof), 1);
      chk1("s6_eof_12th", int'(got[11].eof), 1);
    end

    chk1("final_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
